// File: rtl/mem_arb.sv
`timescale 1ns/1ps
// Shared request/response types for the core-to-memory port.
// Requests carry an op, a byte address, write data and a byte mask.
// Responses carry the read word; writes also get a response.
package mem_pkg;
  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  typedef struct packed {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } mem_resp_t;
endpackage

// mem_arb: round-robin (or fixed-priority) arbiter sharing one single-port
//   memory between NREQ requesters; response returns 1 cycle after accept.
// Ports: clk/rst (sync, active-high); m_req_* / m_resp_* per requester;
//   mem_req_* / mem_resp_* toward the memory. A 1-entry skid buffer absorbs
//   response back-pressure; no new grant is issued while it is occupied.
module mem_arb #(
  parameter int NREQ      = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     m_req_valid,
  output logic [NREQ-1:0]     m_req_ready,
  input  mem_pkg::mem_req_t   m_req [NREQ-1:0],
  output logic [NREQ-1:0]     m_resp_valid,
  input  logic [NREQ-1:0]     m_resp_ready,
  output mem_pkg::mem_resp_t  m_resp [NREQ-1:0],
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output mem_pkg::mem_req_t   mem_req,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  mem_pkg::mem_resp_t  mem_resp
);
  localparam int IDW = $clog2(NREQ);

  // In-flight owner (request accepted last cycle)
  logic               infl_vld_q, infl_vld_d;
  logic [IDW-1:0]     infl_id_q, infl_id_d;
  // Skid buffer holding a response its owner did not take
  logic               buf_vld_q, buf_vld_d;
  logic [IDW-1:0]     buf_id_q, buf_id_d;
  mem_pkg::mem_resp_t buf_resp_q, buf_resp_d;
  // Round-robin pointer: index of the most recent grant
  logic [IDW-1:0]     last_gnt_q, last_gnt_d;

  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  logic               stall;
  mem_pkg::mem_resp_t resp_dat;

  // Winner selection. Round-robin scans the indices after last_gnt with
  // wrap-around, so the most recent winner is considered last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    if (PRIO_MODE == 1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_id    = IDW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!gnt_found && m_req_valid[(int'(last_gnt_q) + k) % NREQ]) begin
          gnt_found = 1'b1;
          gnt_id    = IDW'((int'(last_gnt_q) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    m_req_ready   = '0;
    m_resp_valid  = '0;
    mem_req_valid = 1'b0;
    mem_req       = m_req[gnt_id];
    resp_dat      = mem_resp;
    infl_vld_d    = 1'b0;
    infl_id_d     = infl_id_q;
    buf_vld_d     = buf_vld_q;
    buf_id_d      = buf_id_q;
    buf_resp_d    = buf_resp_q;
    last_gnt_d    = last_gnt_q;

    // A new grant would produce a response next cycle; only allow it when the
    // response path is guaranteed free by then.
    stall = buf_vld_q | (mem_resp_valid & infl_vld_q & ~m_resp_ready[infl_id_q]);

    if (buf_vld_q) begin
      m_resp_valid[buf_id_q] = 1'b1;
      resp_dat               = buf_resp_q;
      if (m_resp_ready[buf_id_q]) begin
        buf_vld_d = 1'b0;
      end
    end else if (mem_resp_valid && infl_vld_q) begin
      m_resp_valid[infl_id_q] = 1'b1;
      if (!m_resp_ready[infl_id_q]) begin
        buf_vld_d  = 1'b1;
        buf_id_d   = infl_id_q;
        buf_resp_d = mem_resp;
      end
    end
    // A memory response with nothing in flight is stale and simply ignored.

    if (!stall && gnt_found) begin
      mem_req_valid       = 1'b1;
      m_req_ready[gnt_id] = mem_req_ready;
      if (mem_req_ready) begin
        infl_vld_d = 1'b1;
        infl_id_d  = gnt_id;
        last_gnt_d = gnt_id;
      end
    end

    // Keep handshake outputs quiet while reset is held.
    if (rst) begin
      m_req_ready   = '0;
      m_resp_valid  = '0;
      mem_req_valid = 1'b0;
    end
  end

  assign mem_resp_ready = 1'b1;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign m_resp[i] = resp_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_vld_q <= 1'b0;
      infl_id_q  <= '0;
      buf_vld_q  <= 1'b0;
      buf_id_q   <= '0;
      buf_resp_q <= '0;
      last_gnt_q <= IDW'(NREQ - 1);
    end else begin
      infl_vld_q <= infl_vld_d;
      infl_id_q  <= infl_id_d;
      buf_vld_q  <= buf_vld_d;
      buf_id_q   <= buf_id_d;
      buf_resp_q <= buf_resp_d;
      last_gnt_q <= last_gnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
`timescale 1ns/1ps
module tb_mem_arb;
  import mem_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mem_init;
  logic inject;

  // ---------------- main DUT: NREQ=3, round-robin ----------------
  logic [N-1:0] m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
  mem_req_t     m_req [N-1:0];
  mem_req_t     req_nxt [N-1:0];
  mem_resp_t    m_resp [N-1:0];
  logic         mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  mem_req_t     mem_req;
  mem_resp_t    mem_resp;

  mem_arb #(.NREQ(N), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req(m_req),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp(m_resp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] msk);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (msk[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM: response 1 cycle after accept, returns the
  // word as it was before any write in the same access.
  logic [31:0] tmem [256];
  logic        tm_vld_q = 1'b0;
  logic [31:0] tm_dat_q = '0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tmem[i] <= init_val(i);
      tm_vld_q <= 1'b0;
    end else begin
      tm_vld_q <= mem_req_valid & mem_req_ready;
      if (mem_req_valid & mem_req_ready) begin
        tm_dat_q <= tmem[mem_req.addr[9:2]];
        if (mem_req.op == MEM_WRITE)
          tmem[mem_req.addr[9:2]] <= merge(tmem[mem_req.addr[9:2]], mem_req.wdata, mem_req.wmask);
      end
    end
  end
  assign mem_resp_valid = tm_vld_q | inject;
  assign mem_resp.rdata = tm_dat_q;

  // ---------------- second DUT: NREQ=2, fixed priority ----------------
  logic [1:0] p_req_valid, p_req_ready, p_resp_valid, p_resp_ready;
  mem_req_t   p_req [1:0];
  mem_resp_t  p_resp [1:0];
  logic       p_mem_req_valid, p_mem_req_ready, p_mem_resp_valid, p_mem_resp_ready;
  mem_req_t   p_mem_req;
  mem_resp_t  p_mem_resp;
  logic       p_vld_q = 1'b0;

  mem_arb #(.NREQ(2), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .rst(rst),
    .m_req_valid(p_req_valid), .m_req_ready(p_req_ready), .m_req(p_req),
    .m_resp_valid(p_resp_valid), .m_resp_ready(p_resp_ready), .m_resp(p_resp),
    .mem_req_valid(p_mem_req_valid), .mem_req_ready(p_mem_req_ready), .mem_req(p_mem_req),
    .mem_resp_valid(p_mem_resp_valid), .mem_resp_ready(p_mem_resp_ready), .mem_resp(p_mem_resp)
  );
  always @(posedge clk) p_vld_q <= p_mem_req_valid & p_mem_req_ready;
  assign p_mem_resp_valid = p_vld_q;
  assign p_mem_resp.rdata = 32'h0;

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: at most one response is owed at any time. It is visible
  // on its owner's lane from the cycle after acceptance until taken. A new
  // grant is only allowed when that response is being taken in the same cycle
  // it first appears (or nothing is owed).
  logic [31:0] rmem [256];
  int          rr_last;
  bit          pv, pfresh;
  int          pid;
  logic [31:0] pdat;

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rrdy, input logic mrdy,
                      input logic r, input logic inj, output logic [N-1:0] e_rdy);
    logic [N-1:0] e_rv;
    logic         e_mv;
    bit           stall_m, gf;
    int           g;
    int           a;
    @(negedge clk);
    rst = r; m_req_valid = v; m_resp_ready = rrdy; mem_req_ready = mrdy; inject = inj;
    m_req = req_nxt;
    #2;
    e_rdy = '0; e_rv = '0; e_mv = 1'b0; gf = 0; g = 0;
    if (!r) begin
      stall_m = pv && (!pfresh || !rrdy[pid]);
      if (pv) e_rv[pid] = 1'b1;
      if (!stall_m) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (rr_last + k) % N;
          if (!gf && v[c]) begin gf = 1; g = c; end
        end
      end
      e_mv = gf;
      if (gf && mrdy) e_rdy[g] = 1'b1;
    end
    chk("req_ready", 64'(m_req_ready), 64'(e_rdy));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mv));
    chk("resp_valid", 64'(m_resp_valid), 64'(e_rv));
    if (!r && pv) chk("resp_data", 64'(m_resp[pid].rdata), 64'(pdat));
    if (gf) chk("mem_req_addr", 64'(mem_req.addr), 64'(req_nxt[g].addr));
    if (r) begin
      pv = 0; rr_last = N - 1;
    end else begin
      if (pv) begin
        if (rrdy[pid]) pv = 0;
        else pfresh = 0;
      end
      if (gf && mrdy) begin
        a = int'(req_nxt[g].addr[9:2]);
        pv = 1; pfresh = 1; pid = g; pdat = rmem[a];
        if (req_nxt[g].op == MEM_WRITE)
          rmem[a] = merge(rmem[a], req_nxt[g].wdata, req_nxt[g].wmask);
        rr_last = g;
      end
    end
  endtask

  function automatic mem_req_t mk(input mem_op_e op, input logic [31:0] ad,
                                  input logic [31:0] wd, input logic [3:0] ms);
    mem_req_t q;
    q.op = op; q.addr = ad; q.wdata = wd; q.wmask = ms;
    return q;
  endfunction

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] rrdy;
    logic [N-1:0] x_rdy;
    logic [N-1:0] x_rv;
  } vec_t;

  initial begin
    vec_t         tbl [14];
    logic [N-1:0] er;
    logic [N-1:0] cur_v;
    rst = 1'b1; mem_init = 1'b1; inject = 1'b0;
    m_req_valid = '0; m_resp_ready = '0; mem_req_ready = 1'b1;
    for (int i = 0; i < N; i++) req_nxt[i] = mk(MEM_READ, 32'h0, 32'h0, 4'h0);
    m_req = req_nxt;
    for (int i = 0; i < 256; i++) rmem[i] = init_val(i);
    pv = 0; pfresh = 0; pid = 0; pdat = '0; rr_last = N - 1;
    p_req_valid = 2'b11; p_resp_ready = 2'b11; p_mem_req_ready = 1'b1;
    p_req[0] = mk(MEM_READ, 32'h40, 32'h0, 4'h0);
    p_req[1] = mk(MEM_READ, 32'h80, 32'h0, 4'h0);

    // Reset state
    step('0, 3'b111, 1'b1, 1'b1, 1'b0, er);
    mem_init = 1'b0;
    step('0, 3'b111, 1'b1, 1'b1, 1'b0, er);
    chk("rst_mem_resp_ready", 64'(mem_resp_ready), 64'(1));

    // m0 alone reads 0x10
    req_nxt[0] = mk(MEM_READ, 32'h10, 32'h0, 4'h0);
    step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0, er);
    chk("t1_grant", 64'(m_req_ready), 64'(3'b001));
    step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0, er);
    chk("t1_resp_lane", 64'(m_resp_valid), 64'(3'b001));
    chk("t1_data", 64'(m_resp[0].rdata), 64'(init_val(4)));

    // m1 writes 0x20, then m0 reads it back
    req_nxt[1] = mk(MEM_WRITE, 32'h20, 32'hDEADBEEF, 4'b1111);
    step(3'b010, 3'b111, 1'b1, 1'b0, 1'b0, er);
    req_nxt[0] = mk(MEM_READ, 32'h20, 32'h0, 4'h0);
    step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0, er);
    step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0, er);
    chk("t3_readback", 64'(m_resp[0].rdata), 64'(32'hDEADBEEF));

    // Table: rotation, skid-buffer stalls, grant resumption.
    // Also checks the fixed-priority instance, where m1 always wins.
    tbl = '{
      '{3'b001, 3'b111, 3'b001, 3'b000},
      '{3'b011, 3'b111, 3'b010, 3'b001},
      '{3'b111, 3'b111, 3'b100, 3'b010},
      '{3'b111, 3'b111, 3'b001, 3'b100},
      '{3'b110, 3'b110, 3'b000, 3'b001},
      '{3'b110, 3'b111, 3'b000, 3'b001},
      '{3'b110, 3'b111, 3'b010, 3'b000},
      '{3'b100, 3'b111, 3'b100, 3'b010},
      '{3'b001, 3'b011, 3'b000, 3'b100},
      '{3'b001, 3'b011, 3'b000, 3'b100},
      '{3'b001, 3'b011, 3'b000, 3'b100},
      '{3'b001, 3'b111, 3'b000, 3'b100},
      '{3'b001, 3'b111, 3'b001, 3'b000},
      '{3'b000, 3'b111, 3'b000, 3'b001}
    };
    for (int i = 0; i < N; i++) req_nxt[i] = mk(MEM_READ, 32'(4 * (i + 8)), 32'h0, 4'h0);
    step('0, 3'b111, 1'b1, 1'b1, 1'b0, er);
    for (int t = 0; t < 14; t++) begin
      step(tbl[t].v, tbl[t].rrdy, 1'b1, 1'b0, 1'b0, er);
      chk($sformatf("tbl%0d_rdy", t), 64'(m_req_ready), 64'(tbl[t].x_rdy));
      chk($sformatf("tbl%0d_rv", t), 64'(m_resp_valid), 64'(tbl[t].x_rv));
      chk("prio_rdy", 64'(p_req_ready), 64'(2'b10));
      chk("prio_addr", 64'(p_mem_req.addr), 64'(32'h80));
      if (t > 0) chk("prio_rv", 64'(p_resp_valid), 64'(2'b10));
    end

    // Reset right after a grant; stray memory response afterwards is ignored
    step(3'b011, 3'b111, 1'b1, 1'b0, 1'b0, er);
    step(3'b011, 3'b111, 1'b1, 1'b1, 1'b0, er);
    chk("t5_rst_rv", 64'(m_resp_valid), 64'(0));
    step(3'b011, 3'b111, 1'b1, 1'b0, 1'b1, er);
    chk("t5_first_grant", 64'(m_req_ready), 64'(3'b001));
    chk("t5_stray_drop", 64'(m_resp_valid), 64'(3'b000));
    step(3'b010, 3'b111, 1'b1, 1'b0, 1'b0, er);
    step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0, er);

    // Random traffic; requests held stable until accepted
    cur_v = '0;
    er = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(cur_v[i] && !er[i])) begin
          cur_v[i] = ($urandom % 100) < 60;
          req_nxt[i] = mk(($urandom % 3 == 0) ? MEM_WRITE : MEM_READ,
                          32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom));
        end
      end
      step(cur_v, N'($urandom), ($urandom % 8) != 0, 1'b0, 1'b0, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
